// File: rtl/led_pkg.sv
// Shared types and default 100 MHz timing for the single-wire LED strip driver.
package led_pkg;

  localparam int unsigned T0H      = 40;
  localparam int unsigned T1H      = 80;
  localparam int unsigned TBIT     = 125;
  localparam int unsigned TLATCH   = 5000;
  localparam int unsigned PIX_BITS = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  // Colour word exactly as produced by the lights selector stage.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } light_t;

  // Pixels expect green first, then red, then blue, each MSB first.
  function automatic logic [23:0] wire_order(input light_t c);
    return {c.g, c.r, c.b};
  endfunction

endpackage

// File: rtl/led_strip_driver_if.sv
// Frame request / serial output bundle between the selector stage and the strip driver.
interface led_strip_driver_if;

  led_pkg::light_t light;
  logic            load;
  logic            dout;
  logic            busy;
  logic            done;

  modport master (output light, output load, input dout, input busy, input done);
  modport slave  (input light, input load, output dout, output busy, output done);

endinterface

// File: rtl/led_bit_timer.sv
// Per-bit cycle counter and high-time compare for the serial waveform.
module led_bit_timer
  import led_pkg::*;
#(
  parameter int unsigned CLK_T0H  = T0H,
  parameter int unsigned CLK_T1H  = T1H,
  parameter int unsigned CLK_TBIT = TBIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  input  logic bit_next,
  output logic last_c,
  output logic high_next_c
);

  localparam int unsigned CW = (CLK_TBIT > 1) ? $clog2(CLK_TBIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_TBIT - 1);
  localparam logic [CW-1:0] CNT_T0H  = CW'(CLK_T0H);
  localparam logic [CW-1:0] CNT_T1H  = CW'(CLK_T1H);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  assign last_c = (cnt == CNT_LAST);

  // Count through one bit period, restarting at the frame start.
  always_comb begin
    cnt_next = cnt;
    if (clear) begin
      cnt_next = '0;
    end else if (run) begin
      cnt_next = last_c ? '0 : cnt + CW'(1);
    end
  end

  // Line level for the coming cycle, judged against the bit about to be on the wire.
  assign high_next_c = (cnt_next < (bit_next ? CNT_T1H : CNT_T0H));

  // Bit-period counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/led_strip_driver.sv
// Serialises one captured colour to NUM_LEDS chained pixels, then holds the latch gap.
module led_strip_driver
  import led_pkg::*;
#(
  parameter int unsigned CLK_T0H    = T0H,
  parameter int unsigned CLK_T1H    = T1H,
  parameter int unsigned CLK_TBIT   = TBIT,
  parameter int unsigned CLK_TLATCH = TLATCH,
  parameter int unsigned NUM_LEDS   = 8
) (
  input  logic               clk,
  input  logic               rst,
  led_strip_driver_if.slave  bus
);

  localparam int unsigned PW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int unsigned LW = (CLK_TLATCH > 1) ? $clog2(CLK_TLATCH) : 1;
  localparam int unsigned BW = $clog2(PIX_BITS);
  localparam logic [PW-1:0] PIX_LAST = PW'(NUM_LEDS - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(CLK_TLATCH - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(PIX_BITS - 1);

  state_t        state, state_next;
  light_t        hold, hold_next;
  logic [23:0]   shreg, shreg_next;
  logic [BW-1:0] bit_idx, bit_idx_next;
  logic [PW-1:0] pix, pix_next;
  logic [LW-1:0] lat, lat_next;
  logic          dout, dout_next;
  logic          busy, busy_next;
  logic          done, done_next;
  logic          timer_clear, timer_run, timer_last_c, high_next_c;

  led_bit_timer #(
    .CLK_T0H  (CLK_T0H),
    .CLK_T1H  (CLK_T1H),
    .CLK_TBIT (CLK_TBIT)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .clear       (timer_clear),
    .run         (timer_run),
    .bit_next    (shreg_next[23]),
    .last_c      (timer_last_c),
    .high_next_c (high_next_c)
  );

  // Next-state, shift and counter logic for IDLE / SEND / LATCH.
  always_comb begin
    state_next   = state;
    hold_next    = hold;
    shreg_next   = shreg;
    bit_idx_next = bit_idx;
    pix_next     = pix;
    lat_next     = lat;
    done_next    = 1'b0;
    timer_clear  = 1'b0;
    timer_run    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.load) begin
          state_next   = ST_SEND;
          hold_next    = bus.light;
          shreg_next   = wire_order(bus.light);
          bit_idx_next = '0;
          pix_next     = '0;
          timer_clear  = 1'b1;
        end
      end
      ST_SEND: begin
        timer_run = 1'b1;
        if (timer_last_c) begin
          if (bit_idx == BIT_LAST) begin
            bit_idx_next = '0;
            shreg_next   = wire_order(hold);
            if (pix == PIX_LAST) begin
              pix_next   = '0;
              lat_next   = '0;
              state_next = ST_LATCH;
            end else begin
              pix_next = pix + PW'(1);
            end
          end else begin
            bit_idx_next = bit_idx + BW'(1);
            shreg_next   = {shreg[22:0], 1'b0};
          end
        end
      end
      ST_LATCH: begin
        if (lat == LAT_LAST) begin
          lat_next   = '0;
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end else begin
          lat_next = lat + LW'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output levels for the coming cycle; the line only goes high while sending.
  assign dout_next = (state_next == ST_SEND) && high_next_c;
  assign busy_next = (state_next != ST_IDLE);

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      hold    <= '0;
      shreg   <= '0;
      bit_idx <= '0;
      pix     <= '0;
      lat     <= '0;
      dout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      hold    <= hold_next;
      shreg   <= shreg_next;
      bit_idx <= bit_idx_next;
      pix     <= pix_next;
      lat     <= lat_next;
      dout    <= dout_next;
      busy    <= busy_next;
      done    <= done_next;
    end
  end

  assign bus.dout = dout;
  assign bus.busy = busy;
  assign bus.done = done;

endmodule
